// File: rtl/guarded_counter_checker.sv
// guarded_counter_checker: receive-side checker for a guarded counter link (guards, +1 continuity, lock/fault)
module guarded_counter_checker #(
  parameter int WIDTH       = 8,
  parameter int GUARD_BITS  = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int FAULT_LIMIT = 3,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_count,
  input  logic [GUARD_BITS-1:0] in_even,
  input  logic [GUARD_BITS-1:0] in_odd,
  input  logic                  clear_err,
  output logic                  locked,
  output logic                  fault,
  output logic                  guard_err,
  output logic                  seq_err,
  output logic                  restart,
  output logic [WIDTH-1:0]      expected,
  output logic [ERR_CNT_W-1:0]  err_count
);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W = $clog2(FAULT_LIMIT + 1);
  typedef enum logic [1:0] {ACQUIRE, LOCKED, FAULT} state_t;
  state_t                r_state, w_next;
  logic                  r_v, r_clr, r_refv, w_refv_n;
  logic [WIDTH-1:0]      r_c, r_ref, w_ref_n, r_exp, w_exp_n;
  logic [GUARD_BITS-1:0] r_e, r_o, w_even, w_odd;
  logic [RUN_W-1:0]      r_run, w_run_n;
  logic [BAD_W-1:0]      r_bad, w_bad_n;
  logic [ERR_CNT_W-1:0]  r_err, w_err_n;
  logic                  r_gerr, r_serr, r_rstp, w_gerr, w_serr, w_rstp;
  logic                  w_good, w_inseq;
  // Sample stage: every input is registered before it is judged, clear_err travels with its sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v   <= 1'b0;
      r_clr <= 1'b0;
      r_c   <= '0;
      r_e   <= '0;
      r_o   <= '0;
    end else begin
      r_v   <= in_valid;
      r_clr <= clear_err;
      r_c   <= in_count;
      r_e   <= in_even;
      r_o   <= in_odd;
    end
  // Recompute the even/odd guard sums of the sampled count (modulo 2^GUARD_BITS by width)
  always_comb begin
    w_even = '0;
    w_odd  = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i % 2 == 0) w_even = w_even + GUARD_BITS'(r_c[i]);
      else            w_odd  = w_odd + GUARD_BITS'(r_c[i]);
    w_good  = (w_even == r_e) && (w_odd == r_o);
    w_inseq = r_c == r_ref + WIDTH'(1);
  end
  // Next-state and next-output logic for the acquire/locked/fault machine
  always_comb begin
    w_next   = r_state;
    w_run_n  = r_run;
    w_bad_n  = r_bad;
    w_ref_n  = r_ref;
    w_refv_n = r_refv;
    w_exp_n  = r_exp;
    w_err_n  = r_err;
    w_gerr   = 1'b0;
    w_serr   = 1'b0;
    w_rstp   = 1'b0;
    if (r_clr) begin
      w_next   = ACQUIRE;
      w_run_n  = '0;
      w_bad_n  = '0;
      w_refv_n = 1'b0;
      w_exp_n  = '0;
      w_err_n  = '0;
    end else if (r_v) begin
      case (r_state)
        ACQUIRE:
          if (!w_good) begin
            w_gerr   = 1'b1;
            w_run_n  = '0;
            w_refv_n = 1'b0;
          end else begin
            w_run_n  = (r_refv && w_inseq) ? r_run + RUN_W'(1) : RUN_W'(1);
            w_ref_n  = r_c;
            w_refv_n = 1'b1;
            if (w_run_n == RUN_W'(LOCK_COUNT)) begin
              w_next  = LOCKED;
              w_exp_n = r_c + WIDTH'(1);
              w_bad_n = '0;
            end
          end
        LOCKED:
          if (w_good && r_c == r_exp) begin
            w_bad_n = '0;
            w_exp_n = r_exp + WIDTH'(1);
          end else if (w_good && r_c == '0 && r_exp != '0) begin
            w_rstp  = 1'b1;
            w_exp_n = WIDTH'(1);
            w_bad_n = '0;
          end else begin
            w_serr  = w_good;
            w_gerr  = !w_good;
            w_exp_n = w_good ? r_c + WIDTH'(1) : r_exp + WIDTH'(1);
            w_err_n = (&r_err) ? r_err : r_err + ERR_CNT_W'(1);
            w_bad_n = r_bad + BAD_W'(1);
            if (w_bad_n == BAD_W'(FAULT_LIMIT)) begin
              w_next  = FAULT;
              w_exp_n = '0;
            end
          end
        default: ;
      endcase
    end
  end
  // State, run counters and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ACQUIRE;
      r_run   <= '0;
      r_bad   <= '0;
      r_ref   <= '0;
      r_refv  <= 1'b0;
      r_exp   <= '0;
      r_err   <= '0;
      r_gerr  <= 1'b0;
      r_serr  <= 1'b0;
      r_rstp  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= w_run_n;
      r_bad   <= w_bad_n;
      r_ref   <= w_ref_n;
      r_refv  <= w_refv_n;
      r_exp   <= w_exp_n;
      r_err   <= w_err_n;
      r_gerr  <= w_gerr;
      r_serr  <= w_serr;
      r_rstp  <= w_rstp;
    end
  assign locked    = r_state == LOCKED;
  assign fault     = r_state == FAULT;
  assign guard_err = r_gerr;
  assign seq_err   = r_serr;
  assign restart   = r_rstp;
  assign expected  = r_exp;
  assign err_count = r_err;
endmodule

// File: tb/tb_guarded_counter_checker.sv
// tb_guarded_counter_checker: directed stimulus with a behavioural model compared every cycle
module tb_guarded_counter_checker;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear_err = 1'b0;
  logic [7:0] in_count = '0;
  logic [1:0] in_even = '0, in_odd = '0;
  logic locked, fault, guard_err, seq_err, restart;
  logic [7:0] expected;
  logic [15:0] err_count;
  logic d2_locked, d2_fault, d2_guard_err, d2_seq_err, d2_restart;
  logic [7:0] d2_expected;
  logic [1:0] d2_err_count;
  int checks = 0, errors = 0;
  bit en = 0;
  always #5 clk = ~clk;
  guarded_counter_checker dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
    .in_even(in_even), .in_odd(in_odd), .clear_err(clear_err), .locked(locked), .fault(fault),
    .guard_err(guard_err), .seq_err(seq_err), .restart(restart), .expected(expected), .err_count(err_count));
  guarded_counter_checker #(.ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_count(in_count), .in_even(in_even), .in_odd(in_odd), .clear_err(clear_err),
    .locked(d2_locked), .fault(d2_fault), .guard_err(d2_guard_err), .seq_err(d2_seq_err),
    .restart(d2_restart), .expected(d2_expected), .err_count(d2_err_count));
  function automatic int gsum(int c, int par);
    int s = 0;
    for (int i = par; i < 8; i += 2) s += (c >> i) & 1;
    return s % 4;
  endfunction
  // Behavioural model: mode 0 acquiring, 1 locked, 2 faulted; one-sample delay before judging
  int mm, mrun, mref, mexp, mbad, merr, pc, pe, po;
  bit mrefv, mg, ms, mr, pv, pclr;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mm = 0; mrun = 0; mref = 0; mrefv = 0; mexp = 0; mbad = 0; merr = 0;
      mg = 0; ms = 0; mr = 0; pv = 0; pclr = 0; pc = 0; pe = 0; po = 0;
    end else begin
      bit good;
      mg = 0; ms = 0; mr = 0;
      good = (pe == gsum(pc, 0)) && (po == gsum(pc, 1));
      if (pclr) begin
        mm = 0; mrun = 0; mrefv = 0; mbad = 0; merr = 0;
      end else if (pv && mm == 0) begin
        if (!good) begin mg = 1; mrun = 0; mrefv = 0; end
        else begin
          mrun = (mrefv && pc == (mref + 1) % 256) ? mrun + 1 : 1;
          mref = pc; mrefv = 1;
          if (mrun >= 4) begin mm = 1; mexp = (pc + 1) % 256; mbad = 0; end
        end
      end else if (pv && mm == 1) begin
        if (good && pc == mexp) begin mbad = 0; mexp = (mexp + 1) % 256; end
        else if (good && pc == 0) begin mr = 1; mexp = 1; mbad = 0; end
        else begin
          if (good) begin ms = 1; mexp = (pc + 1) % 256; end
          else begin mg = 1; mexp = (mexp + 1) % 256; end
          merr++; mbad++;
          if (mbad >= 3) mm = 2;
        end
      end
      pv = in_valid; pc = in_count; pe = in_even; po = in_odd; pclr = clear_err;
    end
  end
  // Cycle-by-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (en) begin
      int xe, e16, e2;
      xe = (mm == 1) ? mexp : 0;
      e16 = merr > 65535 ? 65535 : merr;
      e2 = merr > 3 ? 3 : merr;
      checks++;
      if (locked !== (mm == 1) || fault !== (mm == 2) || guard_err !== mg || seq_err !== ms ||
          restart !== mr || expected !== 8'(xe) || err_count !== 16'(e16) || d2_err_count !== 2'(e2) ||
          d2_locked !== (mm == 1)) begin
        errors++;
        $display("FAIL cycle t=%0t got l=%b f=%b g=%b s=%b r=%b exp=%h err=%0d err2=%0d want l=%b f=%b g=%b s=%b r=%b exp=%h err=%0d err2=%0d",
          $time, locked, fault, guard_err, seq_err, restart, expected, err_count, d2_err_count,
          mm == 1, mm == 2, mg, ms, mr, 8'(xe), e16, e2);
      end
    end
  end
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask
  task automatic drive(bit v, int c, int e, int o, bit clr);
    @(posedge clk);
    #2;
    in_valid = v; in_count = 8'(c); in_even = 2'(e); in_odd = 2'(o); clear_err = clr;
  endtask
  task automatic sendg(int c);
    drive(1, c, gsum(c, 0), gsum(c, 1), 0);
  endtask
  task automatic sendb(int c);
    drive(1, c, gsum(c, 0) ^ 1, gsum(c, 1), 0);
  endtask
  task automatic flush();
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    chk("guard_even_05", gsum(5, 0), 2);
    chk("guard_odd_05", gsum(5, 1), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    en = 1;
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    chk("rst_expected", expected, 0);
    chk("rst_err", err_count, 0);
    for (int c = 5; c <= 8; c++) sendg(c);
    flush();
    chk("t1_locked", locked, 1);
    chk("t1_expected", expected, 8'h09);
    chk("t1_err", err_count, 0);
    for (int c = 9; c <= 'hFC; c++) sendg(c);
    sendg('hFD); sendg('hFE); sendg('hFF); sendg(0); sendg(1);
    flush();
    chk("t2_expected", expected, 8'h02);
    chk("t2_err", err_count, 0);
    chk("t2_locked", locked, 1);
    for (int c = 2; c <= 'h0F; c++) sendg(c);
    sendb('h10);
    flush();
    chk("t3_guard_err", guard_err, 1);
    chk("t3_err", err_count, 1);
    chk("t3_expected", expected, 8'h11);
    sendg('h11);
    flush();
    chk("t3_relocked", locked, 1);
    chk("t3_guard_clear", guard_err, 0);
    for (int c = 'h12; c <= 'h1F; c++) sendg(c);
    sendg(0);
    flush();
    chk("t4_restart", restart, 1);
    chk("t4_err", err_count, 1);
    chk("t4_expected", expected, 8'h01);
    sendg('h40);
    flush();
    chk("t4_seq_err", seq_err, 1);
    chk("t4_expected2", expected, 8'h41);
    sendg('h41); sendb('h42); sendb('h43); sendb('h44);
    flush();
    chk("t5_fault", fault, 1);
    chk("t5_locked", locked, 0);
    chk("t5_expected", expected, 0);
    chk("t5_err", err_count, 5);
    chk("t5_err_sat", d2_err_count, 3);
    sendg('h45); sendb('h46);
    flush();
    chk("t5_no_pulse", {guard_err, seq_err, restart}, 0);
    chk("t5_held", fault, 1);
    drive(0, 0, 0, 0, 1);
    flush();
    chk("t5_clr_fault", fault, 0);
    chk("t5_clr_err", err_count, 0);
    chk("t5_clr_locked", locked, 0);
    for (int c = 5; c <= 8; c++) sendg(c);
    drive(1, 9, gsum(9, 0), gsum(9, 1), 1);
    sendg('h0A); sendg('h0B); sendg('h0C);
    flush();
    chk("t6_clr_discard", locked, 0);
    sendg('h0D);
    flush();
    chk("t6_relock", locked, 1);
    chk("t6_expected", expected, 8'h0E);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_expected", expected, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    sendg('h0E); sendg('h0F); sendg('h10);
    flush();
    chk("t6_three_good", locked, 0);
    sendg('h11);
    flush();
    chk("t6_four_good", locked, 1);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
